dmem_responder: RTL

Data-memory responder for the pipelined RISC-V core's MEM stage. It consumes the MemRead/MemWrite strobes produced by the main controller and services each access over a fixed, parameterized number of wait states. While an access is in flight it holds the pipeline with `Stall`. It performs byte/halfword/word stores with lane enables, and sign- or zero-extends loads according to `Funct3`.

---
 rtl/riscv_mem_pkg.sv | 61 ++++++
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 107 ++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared memory-access definitions for the RV32I data path: Funct3 codes,
// responder FSM states and lane/extension helpers.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // Size comes from Funct3[1:0]; byte and unsized codes carry no constraint.
  function automatic logic alignment_ok(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return ~a[0];
      2'b10:   return (a == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] lane0;
    lane0 = 4'b0001;
    case (f3)
      F3_B:    return lane0 << a;
      F3_H:    return a[1] ? 4'b1100 : 4'b0011;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B:    return {4{wd[7:0]}};
      F3_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'd0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'd0, h};
      F3_W:    return word;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the pipeline controller and the
// data-memory responder.
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Stall;
  logic        Misaligned;

  modport master (
    output MemRead, MemWrite, Funct3, Addr, WrData,
    input  RdData, Stall, Misaligned
  );

  modport slave (
    input  MemRead, MemWrite, Funct3, Addr, WrData,
    output RdData, Stall, Misaligned
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read
// port that only updates when a read is requested.
module dmem_array #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    // Holding the read register keeps the last load result stable between loads.
    if (re) r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: stalls the pipeline for a fixed number of
// wait states, commits lane-masked stores and returns extended load data.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [2:0] CNT_INIT = NO_WAIT ? 3'd0 : 3'(WAIT_CYCLES - 1);

  dmem_state_t       r_state;
  logic [2:0]        r_cnt;
  logic              r_rd_clr;
  logic [2:0]        r_ld_f3;
  logic [1:0]        r_ld_off;

  logic              w_req;
  logic              w_is_wr;
  logic              w_is_rd;
  logic              w_aligned;
  logic              w_idle;
  logic              w_accept;
  logic              w_reject;
  logic              w_enter_resp;
  logic              w_we;
  logic              w_re;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic [ADDR_W-1:0] w_word;
  logic              w_unused;

  assign w_req     = bus.MemRead | bus.MemWrite;
  assign w_is_wr   = bus.MemWrite;
  assign w_is_rd   = bus.MemRead & ~bus.MemWrite;
  assign w_aligned = alignment_ok(bus.Funct3, bus.Addr[1:0]);
  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle & w_req & w_aligned;
  assign w_reject  = w_idle & w_req & ~w_aligned;

  // The request is held stable by the stall, so the live inputs are still valid
  // on the edge that enters RESP; an asserted reset drops that commit.
  assign w_enter_resp = ((r_state == ST_WAIT) && (r_cnt == 3'd0)) || (NO_WAIT && w_accept);
  assign w_we         = reset & w_enter_resp & w_is_wr;
  assign w_re         = reset & w_enter_resp & w_is_rd;

  assign w_word   = bus.Addr[ADDR_W+1:2];
  assign w_be     = byte_enable(bus.Funct3, bus.Addr[1:0]);
  assign w_wdata  = store_data(bus.Funct3, bus.WrData);
  assign w_unused = ^bus.Addr[31:ADDR_W+2];

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .re    (w_re),
    .be    (w_be),
    .addr  (w_word),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_rd_clr <= 1'b1;
      r_ld_f3  <= 3'd0;
      r_ld_off <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= NO_WAIT ? ST_RESP : ST_WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) r_state <= ST_RESP;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_reject) begin
        r_rd_clr <= 1'b1;
      end else if (w_re) begin
        r_rd_clr <= 1'b0;
        r_ld_f3  <= bus.Funct3;
        r_ld_off <= bus.Addr[1:0];
      end
    end
  end

  assign bus.RdData     = r_rd_clr ? 32'd0 : load_extend(r_ld_f3, r_ld_off, w_rdata);
  assign bus.Stall      = w_accept | (r_state == ST_WAIT);
  assign bus.Misaligned = w_reject;

endmodule
